// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive synchroniser: FSM states, default
// sizes and the sample-edge selection helper.
package spi_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling edge.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Receive word FIFO; a push while full is accepted only when a pop frees a
// slot in the same cycle.
module spi_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == (AW+1)'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/spi_rx_sync.sv
// SPI receiver clocked by the system clock: oversamples sclk/cs_n/miso,
// assembles words and queues them in a small FIFO.
//   state     | meaning
//   ST_IDLE   | chip deselected, sample edges ignored
//   ST_ACTIVE | chip selected, shifting bits on each sample edge
module spi_rx_sync
    import spi_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter bit LSB_FIRST   = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpol,
    input  logic                     cpha,
    input  logic                     sclk,
    input  logic                     cs_n,
    input  logic                     miso,
    output logic [WIDTH-1:0]         rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     busy,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_miso_sync;
    logic                   r_sclk_hist;
    spi_state_t             r_state;
    spi_state_t             w_state_nxt;
    logic [CW-1:0]          r_bit_cnt;
    logic [WIDTH-1:0]       r_shift;
    logic [WIDTH-1:0]       w_shift_nxt;
    logic                   r_cpol;
    logic                   r_cpha;
    logic                   r_push;
    logic [WIDTH-1:0]       r_push_word;
    logic                   r_frame_err;
    logic                   r_overflow;
    logic                   w_sclk_s;
    logic                   w_cs_s;
    logic                   w_miso_s;
    logic                   w_sample;
    logic                   w_enter;
    logic                   w_leave;
    logic                   w_shift_en;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '1;
            r_cs_sync   <= '1;
            r_miso_sync <= '0;
            r_sclk_hist <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_miso_sync <= {r_miso_sync[SYNC_STAGES-2:0], miso};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_miso_s = r_miso_sync[SYNC_STAGES-1];
    assign w_sample = sample_on_rise(r_cpol, r_cpha) ? (w_sclk_s & ~r_sclk_hist)
                                                     : (~w_sclk_s & r_sclk_hist);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (!w_cs_s) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_cs_s)  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_enter    = (r_state == ST_IDLE) && (w_state_nxt == ST_ACTIVE);
    assign w_leave    = (r_state == ST_ACTIVE) && (w_state_nxt == ST_IDLE);
    assign w_shift_en = (r_state == ST_ACTIVE) && !w_cs_s && w_sample;

    always_comb begin
        w_shift_nxt = '0;
        if (LSB_FIRST) w_shift_nxt = {w_miso_s, r_shift[WIDTH-1:1]};
        else           w_shift_nxt = {r_shift[WIDTH-2:0], w_miso_s};
    end

    // The push is registered once more so a word lands SYNC_STAGES+2 cycles after its pin edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_push      <= 1'b0;
            r_push_word <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_enter) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_cpol    <= cpol;
                r_cpha    <= cpha;
            end else if (w_leave) begin
                r_frame_err <= (r_bit_cnt != '0);
                r_bit_cnt   <= '0;
                r_shift     <= '0;
            end else if (w_shift_en) begin
                r_shift <= w_shift_nxt;
                if (r_bit_cnt == CW'(WIDTH-1)) begin
                    r_bit_cnt   <= '0;
                    r_push      <= 1'b1;
                    r_push_word <= w_shift_nxt;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
            if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign w_pop     = rx_valid && rx_ready;
    assign rx_valid  = !w_empty;
    assign busy      = (r_state == ST_ACTIVE);
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

    spi_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (r_push),
        .wr_data (r_push_word),
        .pop     (w_pop),
        .rd_data (rx_data),
        .full    (w_full),
        .empty   (w_empty),
        .level   (level)
    );

endmodule

// File: tb/tb_spi_rx_sync.sv
// Scoreboarded bench: an MSB-first and an LSB-first receiver share one SPI bus.
`timescale 1ns/1ps
module tb_spi_rx_sync;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst, cpol, cpha, sclk, cs_n, miso, rx_ready;
    logic [7:0] rx_data, rx_data_l;
    logic       rx_valid, rx_valid_l, busy, busy_l, frame_err, frame_err_l;
    logic       overflow, overflow_l;
    logic [2:0] level, level_l;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_edge = 0;
    int first_valid = -1;
    int fe_cnt = 0;
    logic prev_valid = 1'b0;
    logic [7:0] q_msb[$];
    logic [7:0] q_lsb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_rx_sync #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs_n(cs_n),
        .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .frame_err(frame_err), .overflow(overflow), .level(level));

    spi_rx_sync #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) u_dut_lsb (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs_n(cs_n),
        .miso(miso), .rx_data(rx_data_l), .rx_valid(rx_valid_l), .rx_ready(1'b1),
        .busy(busy_l), .frame_err(frame_err_l), .overflow(overflow_l), .level(level_l));

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // Monitor: pops expected words whenever a receiver hands one over.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) begin
                checks++;
                if (q_msb.size() == 0) begin
                    errors++;
                    $display("FAIL msb_unexpected_word got=%02h", rx_data);
                end else begin
                    logic [7:0] e;
                    e = q_msb.pop_front();
                    if (rx_data !== e) begin
                        errors++;
                        $display("FAIL msb_word got=%02h exp=%02h", rx_data, e);
                    end
                end
            end
            if (rx_valid_l) begin
                checks++;
                if (q_lsb.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_unexpected_word got=%02h", rx_data_l);
                end else begin
                    logic [7:0] e;
                    e = q_lsb.pop_front();
                    if (rx_data_l !== e) begin
                        errors++;
                        $display("FAIL lsb_word got=%02h exp=%02h", rx_data_l, e);
                    end
                end
            end
            if (frame_err) fe_cnt++;
            if (rx_valid && !prev_valid && first_valid < 0) first_valid = cyc;
            prev_valid = rx_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic expect_msb(input logic [7:0] w);
        q_msb.push_back(w);
    endtask

    task automatic expect_lsb(input logic [7:0] w);
        q_lsb.push_back(rev8(w));
    endtask

    task automatic send_word(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                miso = w[7-i];
                tick(H);
                sclk = ~sclk;
                last_edge = cyc;
                tick(H);
                sclk = ~sclk;
            end else begin
                sclk = ~sclk;
                miso = w[7-i];
                tick(H);
                sclk = ~sclk;
                last_edge = cyc;
                tick(H);
            end
        end
    endtask

    task automatic frame_begin(input logic cp, input logic ch);
        cpol = cp;
        cpha = ch;
        sclk = cp;
        tick(8);
        cs_n = 1'b0;
        tick(H);
    endtask

    task automatic frame_end();
        tick(H);
        cs_n = 1'b1;
        tick(2*H);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0;
        rst = 1'b1; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; cs_n = 1'b1;
        miso = 1'b0; rx_ready = 1'b1;
        tick(3);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", level, 0);
        chk("rst_rx_data", rx_data, 0);
        rst = 1'b0;
        tick(5);

        // Mode 0, single word, latency from the 8th rising edge.
        fe0 = fe_cnt;
        first_valid = -1;
        frame_begin(1'b0, 1'b0);
        chk("busy_active", busy, 1);
        expect_msb(8'hA5); expect_lsb(8'hA5);
        send_word(8'hA5, 8);
        frame_end();
        chk("latency_a5", first_valid - last_edge, 4);
        chk("a5_no_frame_err", fe_cnt - fe0, 0);
        chk("idle_busy", busy, 0);

        // Mode 3 then mode 1.
        frame_begin(1'b1, 1'b1);
        expect_msb(8'h3C); expect_lsb(8'h3C);
        send_word(8'h3C, 8);
        frame_end();
        frame_begin(1'b0, 1'b1);
        expect_msb(8'h3C); expect_lsb(8'h3C);
        send_word(8'h3C, 8);
        expect_msb(8'h01); expect_lsb(8'h01);
        send_word(8'h01, 8);
        frame_end();

        // Three words in one frame, consumer stalled.
        rx_ready = 1'b0;
        frame_begin(1'b0, 1'b0);
        foreach (q_msb[i]) ; // queue already drained by now
        expect_msb(8'h01); expect_lsb(8'h01); send_word(8'h01, 8);
        expect_msb(8'h02); expect_lsb(8'h02); send_word(8'h02, 8);
        expect_msb(8'h03); expect_lsb(8'h03); send_word(8'h03, 8);
        frame_end();
        chk("level_three", level, 3);
        chk("valid_three", rx_valid, 1);
        rx_ready = 1'b1;
        tick(6);
        chk("level_drained", level, 0);

        // Five words into a depth-4 FIFO.
        rx_ready = 1'b0;
        frame_begin(1'b0, 1'b0);
        expect_msb(8'h11); expect_lsb(8'h11); send_word(8'h11, 8);
        expect_msb(8'h22); expect_lsb(8'h22); send_word(8'h22, 8);
        expect_msb(8'h33); expect_lsb(8'h33); send_word(8'h33, 8);
        expect_msb(8'h44); expect_lsb(8'h44); send_word(8'h44, 8);
        chk("overflow_before", overflow, 0);
        expect_lsb(8'h55); send_word(8'h55, 8);
        frame_end();
        chk("level_full", level, 4);
        chk("overflow_set", overflow, 1);
        chk("overflow_lsb_clear", overflow_l, 0);
        rx_ready = 1'b1;
        tick(8);
        chk("level_after_ovf", level, 0);
        chk("overflow_sticky", overflow, 1);

        // Partial frame of 5 bits.
        fe0 = fe_cnt;
        frame_begin(1'b0, 1'b0);
        send_word(8'hF0, 5);
        frame_end();
        chk("frame_err_one_pulse", fe_cnt - fe0, 1);
        chk("level_after_partial", level, 0);
        frame_begin(1'b0, 1'b0);
        expect_msb(8'h5A); expect_lsb(8'h5A);
        send_word(8'h5A, 8);
        frame_end();
        chk("frame_err_after_5a", fe_cnt - fe0, 1);

        // Reset mid-frame.
        fe0 = fe_cnt;
        frame_begin(1'b0, 1'b0);
        send_word(8'hC3, 4);
        rst = 1'b1;
        tick(2);
        cs_n = 1'b1;
        tick(1);
        chk("rst_mid_level", level, 0);
        chk("rst_mid_overflow", overflow, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        tick(4);
        chk("rst_mid_no_frame_err", fe_cnt - fe0, 0);
        frame_begin(1'b0, 1'b0);
        expect_msb(8'hFF); expect_lsb(8'hFF);
        send_word(8'hFF, 8);
        frame_end();
        chk("ff_no_frame_err", fe_cnt - fe0, 0);

        for (int i = 0; i < 50 && (q_msb.size() != 0 || q_lsb.size() != 0); i++) tick(1);
        chk("msb_queue_empty", q_msb.size(), 0);
        chk("lsb_queue_empty", q_lsb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_rx_sync.md
SPI_RX_SYNC -- requirements
Module: spi_rx_sync

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, giving the word length in bits (2..32).
REQ-002 The block SHALL have the parameter DEPTH, default 4, giving the receive FIFO depth in words (power of 2, 2..16).
REQ-003 The block SHALL have the parameter LSB_FIRST, default 0; 0 means MSB-first, 1 means LSB-first.
REQ-004 The block SHALL have the parameter SYNC_STAGES, default 2, giving the synchroniser depth for sclk, cs_n and miso (2..3).
REQ-005 Port clk, input, 1 bit: the single system clock; every flop is clocked on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port cpol, input, 1 bit: SPI clock polarity.
REQ-008 Port cpha, input, 1 bit: SPI clock phase.
REQ-009 Port sclk, input, 1 bit: asynchronous SPI clock.
REQ-010 Port cs_n, input, 1 bit: asynchronous active-low chip select.
REQ-011 Port miso, input, 1 bit: asynchronous serial data.
REQ-012 Port rx_data, output, WIDTH bits: the word at the FIFO head.
REQ-013 Port rx_valid, output, 1 bit: the FIFO is non-empty.
REQ-014 Port rx_ready, input, 1 bit: the consumer accepts the head word.
REQ-015 Port busy, output, 1 bit: the FSM is in the ACTIVE state.
REQ-016 Port frame_err, output, 1 bit: one-cycle pulse flagging a partial word at deselect.
REQ-017 Port overflow, output, 1 bit: sticky flag; a word was dropped.
REQ-018 Port level, output, $clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-019 sclk, cs_n and miso SHALL each pass through SYNC_STAGES flops, plus one history flop on sclk for edge detection.
REQ-020 The sample edge SHALL be the rising edge of synchronised sclk when cpol==cpha, otherwise the falling edge.
REQ-021 cpol and cpha SHALL be captured on entry to ACTIVE and held constant until the block returns to IDLE.
REQ-022 The FSM SHALL have two states, IDLE and ACTIVE; IDLE moves to ACTIVE when synchronised cs_n is low, and ACTIVE moves to IDLE when synchronised cs_n is high.
REQ-023 On every IDLE-to-ACTIVE transition, bit_cnt and the shift register SHALL clear.
REQ-024 In ACTIVE, each sample edge SHALL shift in synchronised miso (MSB-first: shift left, insert at bit 0; LSB-first: shift right, insert at bit WIDTH-1) and increment bit_cnt.
REQ-025 When the sample edge with bit_cnt==WIDTH-1 occurs, the completed word (including the current bit) SHALL be pushed and bit_cnt SHALL wrap to 0 with the FSM staying in ACTIVE, so multi-word frames are supported.
REQ-026 A word push SHALL become visible on rx_valid and rx_data exactly SYNC_STAGES+2 clk cycles after the completing sclk edge at the pin.
REQ-027 If the FIFO is full at push time and no pop occurs in the same cycle, the word SHALL be dropped and overflow SHALL set.
REQ-028 overflow SHALL remain set until rst.
REQ-029 A pop SHALL occur when rx_valid && rx_ready; rx_data SHALL update to the next word on the following cycle.
REQ-030 A pop while the FIFO is empty SHALL be ignored.
REQ-031 A simultaneous push and pop SHALL be legal at any level, including full: level is unchanged and no overflow occurs.
REQ-032 On the ACTIVE-to-IDLE transition with bit_cnt!=0, frame_err SHALL pulse high for exactly one cycle, the partial word SHALL be discarded, and nothing SHALL be pushed.
REQ-033 On the ACTIVE-to-IDLE transition with bit_cnt==0, frame_err SHALL stay low.
REQ-034 Sample edges in IDLE SHALL be ignored.
REQ-035 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-036 level SHALL range from 0 to DEPTH inclusive.
REQ-037 Correct operation SHALL be guaranteed only while the sclk half-period is at least 3 clk cycles.

Reset
REQ-038 When rst is high at a clk edge, the FSM SHALL go to IDLE and bit_cnt, shift register, pointers and level SHALL go to 0.
REQ-039 At the same reset, rx_valid, busy, frame_err and overflow SHALL go to 0 and rx_data SHALL go to all-zeros.
REQ-040 Synchroniser flops SHALL reset to 1 for sclk and cs_n, and to 0 for miso.
REQ-041 A reset mid-frame SHALL discard the partial word without a frame_err pulse.
REQ-042 After a reset mid-frame, the block SHALL enter ACTIVE only on the next low synchronised cs_n.

Structure
REQ-043 The shared package spi_pkg SHALL hold the FSM state enumeration, the sample-edge select function of (cpol, cpha), and the default WIDTH and DEPTH constants.
REQ-044 The FIFO SHALL be a separate sub-module, spi_rx_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, level), instantiated once.

Verification
REQ-045 Mode 0, WIDTH=8, MSB-first, send 0xA5 then deselect: rx_data=0xA5, rx_valid high SYNC_STAGES+2 cycles after the 8th rising sclk, frame_err=0.
REQ-046 Mode 3, then mode 1, each sending 0x3C, with LSB_FIRST=1: both words received as 0x3C, confirming the capture edge per mode.
REQ-047 A single cs_n-low frame of 3 words 0x01, 0x02, 0x03 with rx_ready=0: level=3, then pops yield 0x01, 0x02, 0x03 in order.
REQ-048 DEPTH=4, 5 words with rx_ready=0: level=4, overflow=1, the 5th word is lost, and the first 4 are intact.
REQ-049 cs_n rises after 5 bits: frame_err is a one-cycle pulse, level is unchanged, and the next full frame 0x5A is received correctly.
REQ-050 rst asserted after 4 bits, then a new frame 0xFF: no frame_err, level=0 after reset, and 0xFF is received.
